// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- receiver FSM encoding, oversampling ratio and mid-bit sample points.
// Revision 1.0
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int UART_OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_EARLY = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LATE  = 4'd9;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// uart_baud_tick -- free-running divisor counter emitting a one-cycle tick every DIVISOR clocks.
// Revision 1.0
module uart_baud_tick #(
  parameter int DIVISOR = 651
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// uart_rx_frontend -- 16x oversampling 8N1 receiver with one-entry holding register.
// Optional 8E1 framing when UART_RX_PARITY_EN is defined. Revision 1.0
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  input  logic       rx_clr
);

  localparam int DIVISOR = CLK_HZ / (BAUD * OVERSAMPLE);

  logic rx_meta, rxs;
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rxs     <= rx_meta;
    end
  end

  logic tick;
  uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud (
    .clk  (sysclk),
    .rst  (reset),
    .tick (tick)
  );

  rx_state_t  state, state_nxt;
  logic [3:0] sc, sc_inc;
  logic       s_early, s_mid;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       decide, bit_val, parity_ok;
  logic       sc_clr, deliver, frame_err;

  // Sample points are indexed by the post-increment count, so the detect tick is sample 0.
  assign sc_inc  = sc + 4'd1;
  assign decide  = tick && (state != ST_IDLE) && (state != ST_BREAK) && (sc_inc == SAMPLE_LATE);
  assign bit_val = majority3(s_early, s_mid, rxs);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      par_bit <= 1'b0;
    else if (decide && state == ST_PARITY)
      par_bit <= bit_val;
  end
  assign parity_ok = ~(^shreg ^ par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sc_clr    = 1'b0;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && !rxs) begin
          state_nxt = ST_START;
          sc_clr    = 1'b1;
        end
      end
      ST_START: begin
        if (decide)
          state_nxt = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (decide)
          state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (decide) begin
          if (!bit_val) begin
            frame_err = 1'b1;
            state_nxt = ST_BREAK;
          end else begin
            state_nxt = ST_IDLE;
            deliver   = parity_ok;
            frame_err = ~parity_ok;
          end
        end
      end
      ST_BREAK: begin
        if (rxs)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sc      <= 4'd0;
      s_early <= 1'b1;
      s_mid   <= 1'b1;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else begin
      if (sc_clr)
        sc <= 4'd0;
      else if (tick)
        sc <= sc_inc;
      if (tick && sc_inc == SAMPLE_EARLY)
        s_early <= rxs;
      if (tick && sc_inc == SAMPLE_MID)
        s_mid <= rxs;
      if (state == ST_START)
        bit_idx <= 3'd0;
      else if (decide && state == ST_DATA) begin
        shreg   <= {bit_val, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Holding register: a fresh byte may replace one being consumed in the same cycle.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_err;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (deliver && rx_valid && !rx_ready)
        rx_overrun <= 1'b1;
      else if (rx_clr)
        rx_overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire
